ttd_chan_sched: RTL and testbench
=================================

TTD_CHAN_SCHED -- requirements
Module: ttd_chan_sched

Interface
REQ-001 Parameter NCH, default 32: number of time-multiplexed channels sharing one tone/transition detector.
REQ-002 Parameter AW, default 5: channel index width; NCH SHALL be less than or equal to 2**AW.
REQ-003 Parameter TMO, default 15: maximum wait, in cycles, for channel data.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 fs  in  1  frame-sync pulse; starts one pass over all channels.
REQ-007 ch_rd_en  out  1  one-cycle read strobe to the channel state memory (A2P/YL/DQ).
REQ-008 ch_addr  out  AW  channel currently being processed.
REQ-009 ch_rd_valid  in  1  A2P/YL/DQ for ch_addr are valid at the detector inputs.
REQ-010 td  out  1  stored delayed tone-detect bit for ch_addr, driven to the transition detector.
REQ-011 tdr  in  1  next tone-detect value from the detector trigger logic.
REQ-012 tr  in  1  transition-detect result.
REQ-013 tdp  in  1  tone-detect result.
REQ-014 res_valid  out  1  result available.
REQ-015 res_ready  in  1  downstream accepts the result.
REQ-016 res_chan  out  AW  channel of the result.
REQ-017 res_tr  out  1  captured tr.
REQ-018 res_tdp  out  1  captured tdp.
REQ-019 clr_req  in  1  clear one channel's TD state.
REQ-020 clr_chan  in  AW  channel to clear.
REQ-021 busy  out  1  high in every state except IDLE.
REQ-022 frame_done  out  1  one-cycle pulse at the end of a pass.
REQ-023 overrun  out  1  one-cycle pulse when fs is rejected.
REQ-024 timeout  out  1  one-cycle pulse when a channel is skipped.

Function
REQ-025 The block SHALL hold an NCH-bit TD array, one bit per channel, that replaces a per-channel delay element; td SHALL equal the array bit at ch_addr.
REQ-026 The FSM SHALL have states IDLE, READ, WAIT, EVAL, OUT and DONE.
REQ-027 IDLE: on fs=1, ch_addr loads 0 and the FSM goes to READ.
REQ-028 READ: ch_rd_en=1 for exactly one cycle, then WAIT; the wait counter clears.
REQ-029 WAIT: on ch_rd_valid=1 the FSM goes to EVAL; otherwise the counter increments.
REQ-030 WAIT timeout: when the counter reaches TMO with ch_rd_valid=0, the block pulses timeout, leaves the TD bit unchanged, produces no result and advances to the next channel (READ) or to DONE.
REQ-031 EVAL, one cycle: writes TD[ch_addr]<=tdr and captures tr, tdp and ch_addr into res_tr, res_tdp and res_chan, then goes to OUT.
REQ-032 OUT: res_valid=1 and res_* are held stable until res_ready=1.
REQ-033 OUT transfer: on a cycle with res_valid=1 and res_ready=1, the FSM goes to READ with ch_addr+1, or to DONE if ch_addr=NCH-1.
REQ-034 res_valid SHALL deassert the cycle after the transfer.
REQ-035 Latency: with ch_rd_valid one cycle after ch_rd_en and res_ready held at 1, each channel takes 4 cycles (READ, WAIT, EVAL, OUT).
REQ-036 DONE, one cycle: frame_done=1. If fs=1 in that cycle, the fs is accepted and the FSM goes to READ for channel 0; otherwise it goes to IDLE.
REQ-037 fs in READ, WAIT, EVAL or OUT SHALL be ignored and SHALL pulse overrun; the current pass continues.
REQ-038 clr_req=1 SHALL clear TD[clr_chan] at the next edge in any state.
REQ-039 If clr_req and the EVAL write target the same channel in the same cycle, the clear wins (TD=0), while res_tr and res_tdp still capture the detector values.
REQ-040 clr_chan greater than or equal to NCH SHALL be ignored.
REQ-041 ch_addr SHALL never exceed NCH-1; there is no wrap-around inside a pass.

Reset
REQ-042 While reset=1: state=IDLE, all TD bits=0, ch_addr=0, counter=0, and all outputs 0 (ch_rd_en, res_valid, res_chan, res_tr, res_tdp, busy, frame_done, overrun, timeout).
REQ-043 Reset asserted mid-pass SHALL abort the pass immediately; no result is emitted after release until the next fs.

Verification
REQ-044 Full pass, NCH=32, valid 1 cycle after ch_rd_en, res_ready=1, tdr=1 on all channels -> 32 results for channels 0..31 in order, frame_done 128 cycles after the READ for channel 0, all TD bits=1.
REQ-045 Backpressure: res_ready=0 for 5 cycles on channel 3 -> res_valid held, res_chan=3, res_tr and res_tdp stable, ch_rd_en for channel 4 only after the transfer.
REQ-046 Timeout: ch_rd_valid never asserted for channel 7 -> timeout pulse after 15 WAIT cycles, no result for channel 7, TD[7] unchanged, channel 8 proceeds.
REQ-047 fs during WAIT -> overrun pulse, pass unaffected; fs during DONE -> accepted, ch_addr=0, READ next cycle, no overrun.
REQ-048 clr_req with clr_chan=2 during EVAL of channel 2 with tdr=1 -> TD[2]=0 afterwards, res_chan=2 still produced.
REQ-049 Reset pulse during OUT of channel 10 -> res_valid=0 and busy=0 immediately, all TD bits=0, and a subsequent fs restarts at channel 0.

Source files
------------

// File: rtl/ttd_chan_sched.sv
// Channel scheduler that time-multiplexes one tone/transition detector over NCH
// channels, keeping each channel's delayed tone-detect bit in a local array.
module ttd_chan_sched #(
  parameter int unsigned NCH = 32,
  parameter int unsigned AW  = 5,
  parameter int unsigned TMO = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fs,
  output logic          ch_rd_en,
  output logic [AW-1:0] ch_addr,
  input  logic          ch_rd_valid,
  output logic          td,
  input  logic          tdr,
  input  logic          tr,
  input  logic          tdp,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [AW-1:0] res_chan,
  output logic          res_tr,
  output logic          res_tdp,
  input  logic          clr_req,
  input  logic [AW-1:0] clr_chan,
  output logic          busy,
  output logic          frame_done,
  output logic          overrun,
  output logic          timeout
);

  localparam int unsigned CW = $clog2(TMO + 1);
  localparam logic [AW-1:0] LAST_CH  = AW'(NCH - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);
  localparam logic [AW:0]   NCH_W    = (AW + 1)'(NCH);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_EVAL, S_OUT, S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   addr_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [NCH-1:0]  td_q;
  logic            timeout_nxt, overrun_nxt, capture, adv;

  assign td = td_q[ch_addr];

  // Next-state logic; adv moves to the next channel or ends the pass.
  always_comb begin
    state_nxt   = state;
    addr_nxt    = ch_addr;
    cnt_nxt     = cnt;
    timeout_nxt = 1'b0;
    overrun_nxt = 1'b0;
    capture     = 1'b0;
    adv         = 1'b0;
    case (state)
      S_IDLE: begin
        if (fs) begin
          state_nxt = S_READ;
          addr_nxt  = '0;
        end
      end
      S_READ: begin
        overrun_nxt = fs;
        cnt_nxt     = '0;
        state_nxt   = S_WAIT;
      end
      S_WAIT: begin
        overrun_nxt = fs;
        if (ch_rd_valid) begin
          state_nxt = S_EVAL;
        end else begin
          cnt_nxt = cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            timeout_nxt = 1'b1;
            adv         = 1'b1;
          end
        end
      end
      S_EVAL: begin
        overrun_nxt = fs;
        capture     = 1'b1;
        state_nxt   = S_OUT;
      end
      S_OUT: begin
        overrun_nxt = fs;
        if (res_ready) adv = 1'b1;
      end
      S_DONE: begin
        if (fs) begin
          state_nxt = S_READ;
          addr_nxt  = '0;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (adv) begin
      if (ch_addr == LAST_CH) begin
        state_nxt = S_DONE;
      end else begin
        state_nxt = S_READ;
        addr_nxt  = ch_addr + AW'(1);
      end
    end
  end

  // State register with status strobes decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      ch_addr    <= '0;
      cnt        <= '0;
      ch_rd_en   <= 1'b0;
      res_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_nxt;
      ch_addr    <= addr_nxt;
      cnt        <= cnt_nxt;
      ch_rd_en   <= (state_nxt == S_READ);
      res_valid  <= (state_nxt == S_OUT);
      busy       <= (state_nxt != S_IDLE);
      frame_done <= (state_nxt == S_DONE);
      overrun    <= overrun_nxt;
      timeout    <= timeout_nxt;
    end
  end

  // Result capture, held through OUT until accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_chan <= '0;
      res_tr   <= 1'b0;
      res_tdp  <= 1'b0;
    end else if (capture) begin
      res_chan <= ch_addr;
      res_tr   <= tr;
      res_tdp  <= tdp;
    end
  end

  // TD array; the clear is written last so it wins over a same-cycle update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      td_q <= '0;
    end else begin
      if (capture) td_q[ch_addr] <= tdr;
      if (clr_req && ({1'b0, clr_chan} < NCH_W)) td_q[clr_chan] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ttd_chan_sched.sv
// Bench for ttd_chan_sched: a cycle-timed event model of the pass schedule,
// the TD array and the result stream, checked on every falling edge.
module tb_ttd_chan_sched;

  localparam int NCH = 32;
  localparam int AW  = 5;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fs = 1'b0;
  logic          ch_rd_valid = 1'b0;
  logic          tdr, tr, tdp;
  logic          res_ready = 1'b1;
  logic          clr_req = 1'b0;
  logic [AW-1:0] clr_chan = '0;
  logic          ch_rd_en, td, res_valid, res_tr, res_tdp;
  logic          busy, frame_done, overrun, timeout;
  logic [AW-1:0] ch_addr, res_chan;

  logic [NCH-1:0] tdr_pat = '1;
  logic [NCH-1:0] tr_pat  = 32'h3C3C_96A5;
  logic [NCH-1:0] tdp_pat = 32'h5A0F_C3E1;
  logic [NCH-1:0] noresp  = '0;
  int             dly [NCH];

  ttd_chan_sched #(.NCH(NCH), .AW(AW), .TMO(TMO)) dut (
    .clk(clk), .reset(reset), .fs(fs), .ch_rd_en(ch_rd_en), .ch_addr(ch_addr),
    .ch_rd_valid(ch_rd_valid), .td(td), .tdr(tdr), .tr(tr), .tdp(tdp),
    .res_valid(res_valid), .res_ready(res_ready), .res_chan(res_chan),
    .res_tr(res_tr), .res_tdp(res_tdp), .clr_req(clr_req), .clr_chan(clr_chan),
    .busy(busy), .frame_done(frame_done), .overrun(overrun), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Detector stand-in: per-channel patterns presented for the addressed channel.
  always_comb begin
    tdr = tdr_pat[ch_addr];
    tr  = tr_pat[ch_addr];
    tdp = tdp_pat[ch_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Channel memory stand-in: one-cycle valid, dly[ch] cycles after the WAIT entry.
  int valid_at = -10;
  always @(negedge clk) begin
    if (reset) valid_at = -10;
    else if (ch_rd_en && !noresp[ch_addr]) valid_at = cyc + 1 + dly[ch_addr];
  end
  always @(posedge clk) begin
    #1;
    ch_rd_valid = (cyc == valid_at);
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int want);
    n_vec++;
    if (act != want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Model state
  logic [NCH-1:0] m_td = '0;
  int  exp_rd = -1, exp_to = -1, exp_fd = -1, exp_ov = -1;
  int  exp_addr = 0, cur = 0, out_start = 0, stall = 0;
  int  first_rd = 0, rd7 = 0, last_fd = 0, pass_idx = 0;
  bit  pass_on = 0, outstanding = 0, exp_rv = 0;
  logic exp_tr = 1'b0, exp_tdp = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_ch_rd_en", int'(ch_rd_en), 0);
      chk("rst_res_valid", int'(res_valid), 0);
      chk("rst_res_chan", int'(res_chan), 0);
      chk("rst_res_tr", int'(res_tr), 0);
      chk("rst_res_tdp", int'(res_tdp), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_frame_done", int'(frame_done), 0);
      chk("rst_overrun", int'(overrun), 0);
      chk("rst_timeout", int'(timeout), 0);
      chk("rst_ch_addr", int'(ch_addr), 0);
      chk("rst_td", int'(td), 0);
      pass_on = 0; outstanding = 0; m_td = '0;
      exp_rd = -1; exp_to = -1; exp_fd = -1; exp_ov = -1;
    end else begin
      if (cyc == exp_rd) begin
        chk("rd_en", int'(ch_rd_en), 1);
        chk("rd_addr", int'(ch_addr), exp_addr);
        chk("td_at_read", int'(td), int'(m_td[exp_addr]));
        if (exp_addr == 0) begin
          first_rd = cyc;
          if (pass_idx == 3) chk("fs_in_done_restart_lat", cyc - last_fd, 1);
        end
        if (exp_addr == 7) rd7 = cyc;
        if (pass_idx == 2 && exp_addr == 21) chk("td21_cleared_in_idle", int'(td), 0);
        if (pass_idx == 2 && exp_addr == 31) chk("td31_after_full_pass", int'(td), 1);
        if (pass_idx == 3 && exp_addr == 2)  chk("td2_clear_wins", int'(td), 0);
        if (pass_idx == 3 && exp_addr == 7)  chk("td7_kept_on_timeout", int'(td), 1);
        if (pass_idx == 4 && exp_addr == 7)  chk("td7_after_reset", int'(td), 0);
        if (noresp[exp_addr]) begin
          exp_to = cyc + 1 + TMO;
          if (exp_addr == NCH - 1) exp_fd = exp_to;
          else begin
            exp_rd = exp_to;
            exp_addr++;
          end
        end else begin
          outstanding = 1;
          cur = exp_addr;
          out_start = cyc + 3 + dly[cur];
          stall = 0;
        end
      end else begin
        chk("rd_en_quiet", int'(ch_rd_en), 0);
      end

      chk("timeout", int'(timeout), int'(cyc == exp_to));
      if (cyc == exp_to && pass_idx == 2) chk("timeout_latency", cyc - rd7, 16);
      chk("frame_done", int'(frame_done), int'(cyc == exp_fd));
      if (cyc == exp_fd) begin
        if (pass_idx == 1) chk("full_pass_len", cyc - first_rd, 128);
        last_fd = cyc;
      end
      chk("overrun", int'(overrun), int'(cyc == exp_ov));
      chk("busy", int'(busy), int'(pass_on));

      exp_rv = outstanding && (cyc >= out_start);
      chk("res_valid", int'(res_valid), int'(exp_rv));
      if (exp_rv) begin
        chk("res_chan", int'(res_chan), cur);
        chk("res_tr", int'(res_tr), int'(exp_tr));
        chk("res_tdp", int'(res_tdp), int'(exp_tdp));
        stall++;
        if (res_ready) begin
          outstanding = 0;
          if (pass_idx == 2 && cur == 3) chk("backpressure_hold_len", stall, 6);
          if (cur == NCH - 1) exp_fd = cyc + 1;
          else begin
            exp_rd = cyc + 1;
            exp_addr = cur + 1;
          end
        end
      end

      // Effects of the coming rising edge: evaluation write, then clear.
      if (outstanding && cyc == out_start - 1) begin
        m_td[cur] = tdr_pat[cur];
        exp_tr = tr_pat[cur];
        exp_tdp = tdp_pat[cur];
      end
      if (clr_req && int'(clr_chan) < NCH) m_td[clr_chan] = 1'b0;

      if (fs) begin
        if (!pass_on || cyc == exp_fd) begin
          pass_idx++;
          pass_on = 1;
          exp_rd = cyc + 1;
          exp_addr = 0;
        end else begin
          exp_ov = cyc + 1;
        end
      end else if (cyc == exp_fd) begin
        pass_on = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_fs();
    fs = 1'b1;
    step();
    fs = 1'b0;
  endtask

  task automatic wait_read(input int ch);
    bit hit = 0;
    for (int k = 0; k < 400 && !hit; k++) begin
      @(negedge clk);
      hit = ch_rd_en && (ch_addr == AW'(ch));
    end
    if (!hit) begin
      $display("FAIL wait_read: no read strobe for channel %0d within 400 cycles", ch);
      $fatal(1);
    end
  endtask

  task automatic wait_res(input int ch);
    bit hit = 0;
    for (int k = 0; k < 400 && !hit; k++) begin
      @(negedge clk);
      hit = res_valid && (res_chan == AW'(ch));
    end
    if (!hit) begin
      $display("FAIL wait_res: no result for channel %0d within 400 cycles", ch);
      $fatal(1);
    end
  endtask

  task automatic wait_fd();
    bit hit = 0;
    for (int k = 0; k < 1000 && !hit; k++) begin
      @(negedge clk);
      hit = frame_done;
    end
    if (!hit) begin
      $display("FAIL wait_fd: no frame_done within 1000 cycles");
      $fatal(1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NCH; i++) dly[i] = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    step(); step();

    // Pass A: every channel responds at once, tdr=1 everywhere.
    pulse_fs();
    wait_fd();
    step();
    clr_req = 1'b1; clr_chan = AW'(21);
    step();
    clr_req = 1'b0;
    step(); step();

    // Pass B: clear collision, backpressure, timeout, overrun, late valid.
    tdr_pat = ~32'h0000_0080;
    noresp[7] = 1'b1;
    dly[5] = 3;
    dly[12] = TMO - 1;
    pulse_fs();
    wait_read(2);
    step(); step();
    clr_req = 1'b1; clr_chan = AW'(2);
    step();
    clr_req = 1'b0;
    wait_read(3);
    step();
    res_ready = 1'b0;
    step(); step();
    tr_pat[3] = ~tr_pat[3];
    tdp_pat[3] = ~tdp_pat[3];
    repeat (5) @(posedge clk);
    #1 res_ready = 1'b1;
    wait_read(9);
    step();
    fs = 1'b1;
    step();
    fs = 1'b0;
    wait_res(31);
    step();
    fs = 1'b1;
    tdr_pat = 32'h0F0F_0F0F;
    noresp = '0;
    for (int i = 0; i < NCH; i++) dly[i] = 0;
    step();
    fs = 1'b0;

    // Pass C: aborted by reset while channel 10 sits in OUT.
    wait_read(10);
    step();
    res_ready = 1'b0;
    wait_res(10);
    step();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    res_ready = 1'b1;
    repeat (10) step();

    // Pass D: clean restart after reset.
    tdr_pat = 32'hA5A5_A5A5;
    pulse_fs();
    wait_fd();
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
